pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined core. Merges the load-use hazard request, EX-stage taken-branch flush and a multi-cycle data-memory ready handshake into one coherent set of per-stage write-enable and clear signals. It also provides a post-reset pipeline-clear sequence and performance/error counters. It sits beside the hazard detector and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_ctrl_pkg.sv | 56 +++++
 rtl/sat_counter.sv | 35 +++
 rtl/pipeline_stall_controller.sv | 144 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   pipe_state_t : sequencer states (INIT clears the pipe after reset, RUN, MEM_WAIT)
//   stage_ctrl_t : the seven per-stage enable/clear bits driven into the pipeline registers
//   CTRL_*       : canned control patterns for each priority outcome
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        MEM_WAIT
    } pipe_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_clear;
        logic id_ex_write;
        logic id_ex_clear;
        logic ex_mem_write;
        logic mem_wb_clear;
    } stage_ctrl_t;

    localparam int unsigned INIT_CYCLES_DEF  = 4;
    localparam int unsigned MAX_MEM_WAIT_DEF = 15;

    // Post-reset clear: PC held, every register loads a NOP/bubble.
    localparam stage_ctrl_t CTRL_INIT = '{
        pc_write: 1'b0, if_id_write: 1'b1, if_id_clear: 1'b1, id_ex_write: 1'b1,
        id_ex_clear: 1'b1, ex_mem_write: 1'b1, mem_wb_clear: 1'b1
    };

    // Normal flow.
    localparam stage_ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_clear: 1'b0, id_ex_write: 1'b1,
        id_ex_clear: 1'b0, ex_mem_write: 1'b1, mem_wb_clear: 1'b0
    };

    // Memory wait: freeze everything up to EX/MEM, bubble into MEM/WB.
    localparam stage_ctrl_t CTRL_MEM_WAIT = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_clear: 1'b0, id_ex_write: 1'b0,
        id_ex_clear: 1'b0, ex_mem_write: 1'b0, mem_wb_clear: 1'b1
    };

    // Taken branch: redirect PC, squash the two younger instructions.
    localparam stage_ctrl_t CTRL_BRANCH = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_clear: 1'b1, id_ex_write: 1'b1,
        id_ex_clear: 1'b1, ex_mem_write: 1'b1, mem_wb_clear: 1'b0
    };

    // Load-use: hold PC and IF/ID, bubble into ID/EX.
    localparam stage_ctrl_t CTRL_LOAD_USE = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_clear: 1'b0, id_ex_write: 1'b1,
        id_ex_clear: 1'b1, ex_mem_write: 1'b1, mem_wb_clear: 1'b0
    };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous enable.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears the count
//   en_i    : increment by one this cycle (ignored once all-ones)
//   count_o : current count
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage core.
// Merges load-use stalls, EX taken-branch flushes and the data-memory ready handshake
// into per-stage write enables and clears, runs a post-reset clear sequence and keeps
// stall/flush performance counters plus a sticky memory-timeout flag.
//   CLK, RESET_N                : clock (rising) and async active-low reset
//   load_use_hazard             : ID-stage load-use hazard
//   ex_branch_taken             : branch/jump resolved taken in EX
//   mem_req, mem_ready          : MEM-stage access pending / completing this cycle
//   pc_write .. mem_wb_clear    : per-stage controls, combinational from state and inputs
//   mem_timeout                 : sticky, a memory wait reached MAX_MEM_WAIT cycles
//   stall_count, flush_count    : saturating event counters
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES  = INIT_CYCLES_DEF,
    parameter int unsigned MAX_MEM_WAIT = MAX_MEM_WAIT_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             load_use_hazard,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_clear,
    output logic             id_ex_write,
    output logic             id_ex_clear,
    output logic             ex_mem_write,
    output logic             mem_wb_clear,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned WaitW = (MAX_MEM_WAIT > 0) ? $clog2(MAX_MEM_WAIT + 1) : 1;
    localparam logic [InitW-1:0] InitLast = InitW'(INIT_CYCLES - 1);
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(MAX_MEM_WAIT);

    pipe_state_t      state_q, state_d;
    logic [InitW-1:0] init_cnt_q, init_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    stage_ctrl_t      ctrl;
    logic             stall_inc;
    logic             flush_inc;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        ctrl       = CTRL_RUN;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        unique case (state_q)
            INIT: begin
                // Inputs are ignored until the pipe has been fully cleared.
                ctrl = CTRL_INIT;
                if (init_cnt_q == InitLast) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end

            // RUN and MEM_WAIT share one priority table; MEM_WAIT only differs in that
            // leaving item 1 releases the wait and clears the wait counter.
            RUN, MEM_WAIT: begin
                if (mem_req && !mem_ready) begin
                    ctrl       = CTRL_MEM_WAIT;
                    stall_inc  = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
                    if (wait_cnt_d == WaitMax) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (ex_branch_taken) begin
                        // Overrides load-use: the stalled instruction is being squashed.
                        ctrl      = CTRL_BRANCH;
                        flush_inc = 1'b1;
                    end else if (load_use_hazard) begin
                        ctrl      = CTRL_LOAD_USE;
                        stall_inc = 1'b1;
                    end
                end
            end

            default: begin
                ctrl    = CTRL_INIT;
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .en_i    (stall_inc),
        .count_o (stall_count)
    );

    sat_counter #(
        .Width (CNT_W)
    ) u_flush_cnt (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .en_i    (flush_inc),
        .count_o (flush_count)
    );

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_clear  = ctrl.if_id_clear;
    assign id_ex_write  = ctrl.id_ex_write;
    assign id_ex_clear  = ctrl.id_ex_clear;
    assign ex_mem_write = ctrl.ex_mem_write;
    assign mem_wb_clear = ctrl.mem_wb_clear;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios with literal
// expectations, then segmented random stimulus checked every cycle against a
// behavioural model of the stall/flush rules.
module tb_pipeline_stall_controller;

    localparam int unsigned InitCycles = 4;
    localparam int unsigned MaxWait    = 15;
    localparam int unsigned CntW       = 5;
    localparam int          CntMax     = (1 << CntW) - 1;

    logic            CLK;
    logic            RESET_N;
    logic            load_use_hazard;
    logic            ex_branch_taken;
    logic            mem_req;
    logic            mem_ready;
    logic            pc_write;
    logic            if_id_write;
    logic            if_id_clear;
    logic            id_ex_write;
    logic            id_ex_clear;
    logic            ex_mem_write;
    logic            mem_wb_clear;
    logic            mem_timeout;
    logic [CntW-1:0] stall_count;
    logic [CntW-1:0] flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state (owned by the compare process only).
    int m_init_left = InitCycles;
    int m_waits     = 0;
    int m_tmo       = 0;
    int m_stall     = 0;
    int m_flush     = 0;

    pipeline_stall_controller #(
        .INIT_CYCLES  (InitCycles),
        .MAX_MEM_WAIT (MaxWait),
        .CNT_W        (CntW)
    ) dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .load_use_hazard (load_use_hazard),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_clear     (if_id_clear),
        .id_ex_write     (id_ex_write),
        .id_ex_clear     (id_ex_clear),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_clear    (mem_wb_clear),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Control bits packed {pc, if_id_w, if_id_c, id_ex_w, id_ex_c, ex_mem_w, mem_wb_c}.
    function automatic int act_ctrl();
        return int'({pc_write, if_id_write, if_id_clear, id_ex_write, id_ex_clear,
                     ex_mem_write, mem_wb_clear});
    endfunction

    // Compare process: outputs are checked mid-cycle, then the model advances by the
    // rising edge that follows (inputs only change just after rising edges).
    always @(negedge CLK) begin
        int exp_ctrl;
        bit waiting;
        if (!RESET_N) begin
            m_init_left = InitCycles;
            m_waits     = 0;
            m_tmo       = 0;
            m_stall     = 0;
            m_flush     = 0;
        end
        waiting = mem_req && !mem_ready;
        if (!RESET_N || m_init_left > 0) exp_ctrl = 7'b0111111;
        else if (waiting)                exp_ctrl = 7'b0000001;
        else if (ex_branch_taken)        exp_ctrl = 7'b1111110;
        else if (load_use_hazard)        exp_ctrl = 7'b0001110;
        else                             exp_ctrl = 7'b1101010;

        check("ctrl", act_ctrl(), exp_ctrl);
        check("stall_count", int'(stall_count), m_stall);
        check("flush_count", int'(flush_count), m_flush);
        check("mem_timeout", int'(mem_timeout), m_tmo);

        if (RESET_N) begin
            if (m_init_left > 0) begin
                m_init_left--;
            end else if (waiting) begin
                m_waits++;
                if (m_waits >= MaxWait) m_tmo = 1;
                if (m_stall < CntMax) m_stall++;
            end else begin
                m_waits = 0;
                if (ex_branch_taken) begin
                    if (m_flush < CntMax) m_flush++;
                end else if (load_use_hazard) begin
                    if (m_stall < CntMax) m_stall++;
                end
            end
        end
    end

    // One cycle: drive inputs just after the rising edge, return 2 ns later.
    task automatic step(input bit br, input bit lu, input bit req, input bit rdy);
        @(posedge CLK);
        #1;
        ex_branch_taken = br;
        load_use_hazard = lu;
        mem_req         = req;
        mem_ready       = rdy;
        #1;
    endtask

    // Reset for two cycles, release, and run through INIT; the next step() is a RUN cycle.
    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET_N         = 1'b0;
        ex_branch_taken = 1'b0;
        load_use_hazard = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        #1;
        repeat (InitCycles - 1) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit pick(input int pct10);
        return $urandom_range(0, 9) < pct10;
    endfunction

    initial begin
        int req_pct;
        int rdy_pct;
        RESET_N         = 1'b0;
        ex_branch_taken = 1'b0;
        load_use_hazard = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
        #13;
        check("reset pc_write", int'(pc_write), 0);
        check("reset id_ex_clear", int'(id_ex_clear), 1);
        check("reset stall_count", int'(stall_count), 0);
        check("reset mem_timeout", int'(mem_timeout), 0);

        // Reset release: INIT cycles hold PC and clear everything, then normal flow.
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        #1;
        check("init1 pc_write", int'(pc_write), 0);
        check("init1 mem_wb_clear", int'(mem_wb_clear), 1);
        for (int i = 2; i <= InitCycles; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            check("init pc_write", int'(pc_write), 0);
            check("init if_id_clear", int'(if_id_clear), 1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("run pc_write", int'(pc_write), 1);
        check("run clears", int'({if_id_clear, id_ex_clear, mem_wb_clear}), 0);
        check("init ignores inputs", int'(stall_count + flush_count), 0);

        // Single load-use stall.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("lu pc_write", int'(pc_write), 0);
        check("lu if_id_write", int'(if_id_write), 0);
        check("lu id_ex_clear", int'(id_ex_clear), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lu stall_count", int'(stall_count), 1);
        check("lu after pc_write", int'(pc_write), 1);

        // Branch beats load-use.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("br pc_write", int'(pc_write), 1);
        check("br clears", int'({if_id_clear, id_ex_clear}), 3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("br flush_count", int'(flush_count), 1);
        check("br stall_count", int'(stall_count), 0);

        // Three-cycle memory wait, then completion.
        do_reset();
        repeat (3) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            check("mw writes", int'({pc_write, if_id_write, id_ex_write, ex_mem_write}), 0);
            check("mw mem_wb_clear", int'(mem_wb_clear), 1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("mw release ctrl", act_ctrl(), 7'b1101010);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("mw stall_count", int'(stall_count), 3);
        check("mw no timeout", int'(mem_timeout), 0);

        // Long wait: timeout after the 15th waiting cycle, sticky past release.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (k == MaxWait) check("tmo before", int'(mem_timeout), 0);
            if (k == MaxWait + 1) check("tmo rise", int'(mem_timeout), 1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("tmo sticky", int'(mem_timeout), 1);
        check("tmo stall_count", int'(stall_count), 20);

        // Asynchronous reset in the middle of a wait with a pending branch.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        RESET_N = 1'b0;
        #1;
        check("async pc_write", int'(pc_write), 0);
        check("async if_id_clear", int'(if_id_clear), 1);
        check("async stall_count", int'(stall_count), 0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        #1;
        repeat (InitCycles - 1) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("async no flush", int'(flush_count), 0);
        check("async pc after init", int'(pc_write), 1);

        // Random segments with varying memory behaviour; long waits and saturation occur.
        for (int seg = 0; seg < 60; seg++) begin
            req_pct = int'($urandom_range(0, 10));
            rdy_pct = int'($urandom_range(0, 10));
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                end else begin
                    step(pick(2), pick(3), pick(req_pct), pick(rdy_pct));
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
